// File: rtl/ec_curve_param_bank.sv
// Multi-slot elliptic-curve domain parameter store (P, n, a, b, Gx, Gy).
// Slots load word-serially into a shadow buffer and commit atomically; slot 0 resets to secp256k1.
module ec_curve_param_bank #(
  parameter int WIDTH     = 256,
  parameter int NUM_SLOTS = 4,
  parameter int BUS_W     = 32
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         load_start,
  input  logic [$clog2(NUM_SLOTS)-1:0] load_slot,
  input  logic                         load_abort,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [BUS_W-1:0]             wr_data,
  output logic                         load_done,
  output logic                         busy,
  output logic [NUM_SLOTS-1:0]         slot_valid,
  input  logic                         rd_req,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_p,
  output logic [WIDTH-1:0]             rd_n,
  output logic [WIDTH-1:0]             rd_a,
  output logic [WIDTH-1:0]             rd_b,
  output logic [WIDTH-1:0]             rd_gx,
  output logic [WIDTH-1:0]             rd_gy
);

  localparam int WPF = WIDTH / BUS_W;
  localparam int WPS = 6 * WPF;
  localparam int SW  = $clog2(NUM_SLOTS);
  localparam int CW  = $clog2(WPS);
  localparam logic [SW:0]           SLOT_LIM       = (SW+1)'(NUM_SLOTS);
  localparam logic [CW-1:0]         LAST_CNT       = CW'(WPS - 1);
  localparam logic [NUM_SLOTS-1:0]  SLOT_VALID_RST = (WIDTH == 256) ?
      {{(NUM_SLOTS-1){1'b0}}, 1'b1} : {NUM_SLOTS{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [SW-1:0]        tgt_r;
  logic                 wr_ready_r;
  logic                 busy_r;
  logic                 load_done_r;
  logic [NUM_SLOTS-1:0] slot_valid_r;
  logic [BUS_W-1:0]     shadow_r [WPS];
  logic [BUS_W-1:0]     slot_mem_r [NUM_SLOTS][WPS];
  logic                 rd_valid_r;
  logic [WIDTH-1:0]     rd_fld_r [6];

  logic                 accept_s;
  logic                 commit_s;
  logic                 rd_in_range_s;
  logic                 rd_hit_s;
  logic [SW-1:0]        rd_idx_s;
  logic [WIDTH-1:0]     rd_fld_s [6];

  // Word k of the secp256k1 set, in load order (field-major, MS word first).
  function automatic logic [BUS_W-1:0] secp_word(input int k);
    logic [255:0] fld_v;
    logic [2:0]   f_v;
    f_v = 3'(k / WPF);
    case (f_v)
      3'd0:    fld_v = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
      3'd1:    fld_v = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
      3'd2:    fld_v = 256'h0;
      3'd3:    fld_v = 256'h7;
      3'd4:    fld_v = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
      3'd5:    fld_v = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
      default: fld_v = 256'h0;
    endcase
    return fld_v[(WPF-1-(k%WPF))*BUS_W +: BUS_W];
  endfunction

  // Abort wins over a word presented in the same cycle.
  assign accept_s = (state_r == LOAD) & wr_ready_r & wr_valid & ~load_abort;
  assign commit_s = (state_r == COMMIT) & ({1'b0, tgt_r} < SLOT_LIM);

  // Load sequencer: IDLE -> LOAD -> COMMIT, with registered handshake/status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      tgt_r       <= {SW{1'b0}};
      wr_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      load_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_start) begin
            state_r    <= LOAD;
            tgt_r      <= load_slot;
            cnt_r      <= {CW{1'b0}};
            wr_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        LOAD: begin
          if (load_abort) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            wr_ready_r <= 1'b0;
            busy_r     <= 1'b0;
          end else if (accept_s) begin
            if (cnt_r == LAST_CNT) begin
              state_r     <= COMMIT;
              cnt_r       <= {CW{1'b0}};
              wr_ready_r  <= 1'b0;
              load_done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        COMMIT: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CW{1'b0}};
          wr_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
          load_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Shadow buffer capture of accepted words.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < WPS; k++) shadow_r[k] <= {BUS_W{1'b0}};
    end else if (accept_s) begin
      shadow_r[cnt_r] <= wr_data;
    end
  end

  // Committed slot storage; the whole shadow lands in one edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++)
        for (int k = 0; k < WPS; k++)
          slot_mem_r[s][k] <= (s == 0 && WIDTH == 256) ? secp_word(k) : {BUS_W{1'b0}};
    end else if (commit_s) begin
      for (int k = 0; k < WPS; k++) slot_mem_r[tgt_r][k] <= shadow_r[k];
    end
  end

  // Per-slot committed flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_valid_r <= SLOT_VALID_RST;
    end else if (commit_s) begin
      slot_valid_r[tgt_r] <= 1'b1;
    end
  end

  // Read mux: reassemble fields from stored words, MS word first.
  always_comb begin
    rd_in_range_s = ({1'b0, rd_slot} < SLOT_LIM);
    rd_idx_s      = rd_in_range_s ? rd_slot : {SW{1'b0}};
    rd_hit_s      = rd_in_range_s & slot_valid_r[rd_idx_s];
    for (int f = 0; f < 6; f++) begin
      rd_fld_s[f] = {WIDTH{1'b0}};
      for (int w = 0; w < WPF; w++)
        rd_fld_s[f][(WPF-1-w)*BUS_W +: BUS_W] = slot_mem_r[rd_idx_s][f*WPF + w];
    end
  end

  // Registered read port; data holds when no request is made.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid_r <= 1'b0;
      for (int f = 0; f < 6; f++) rd_fld_r[f] <= {WIDTH{1'b0}};
    end else begin
      rd_valid_r <= rd_req;
      if (rd_req) begin
        for (int f = 0; f < 6; f++) rd_fld_r[f] <= rd_hit_s ? rd_fld_s[f] : {WIDTH{1'b0}};
      end
    end
  end

  assign wr_ready   = wr_ready_r;
  assign busy       = busy_r;
  assign load_done  = load_done_r;
  assign slot_valid = slot_valid_r;
  assign rd_valid   = rd_valid_r;
  assign rd_p       = rd_fld_r[0];
  assign rd_n       = rd_fld_r[1];
  assign rd_a       = rd_fld_r[2];
  assign rd_b       = rd_fld_r[3];
  assign rd_gx      = rd_fld_r[4];
  assign rd_gy      = rd_fld_r[5];

endmodule

// File: tb/tb_ec_curve_param_bank.sv
// Randomised bench for ec_curve_param_bank: transaction-level model of the slot store,
// read responses checked by a scoreboard monitor, control outputs checked each cycle.
module tb_ec_curve_param_bank;

  typedef struct packed {
    logic [255:0] p, n, a, b, gx, gy;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         load_start, load_abort, wr_valid, rd_req;
  logic [1:0]   load_slot, rd_slot;
  logic [31:0]  wr_data;
  logic         wr_ready, load_done, busy, rd_valid;
  logic [3:0]   slot_valid;
  logic [255:0] rd_p, rd_n, rd_a, rd_b, rd_gx, rd_gy;

  ec_curve_param_bank dut (
    .Clk(clk), .Reset_n(reset_n),
    .load_start(load_start), .load_slot(load_slot), .load_abort(load_abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .load_done(load_done), .busy(busy), .slot_valid(slot_valid),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_valid(rd_valid),
    .rd_p(rd_p), .rd_n(rd_n), .rd_a(rd_a), .rd_b(rd_b), .rd_gx(rd_gx), .rd_gy(rd_gy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  // Reference model: six whole fields per slot plus a valid flag, and the load progress.
  logic [255:0] m_fld [4][6];
  logic [3:0]   m_val;
  int           ph;       // 0 idle, 1 loading, 2 commit cycle
  int           m_tgt;
  int           m_cnt;
  logic [31:0]  m_words [48];
  bit           last_req;
  int           rd_fix = -1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 4; s++)
      for (int f = 0; f < 6; f++) m_fld[s][f] = 256'h0;
    m_fld[0][0] = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    m_fld[0][1] = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    m_fld[0][2] = 256'h0;
    m_fld[0][3] = 256'h7;
    m_fld[0][4] = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    m_fld[0][5] = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    m_val    = 4'b0001;
    ph       = 0;
    m_cnt    = 0;
    last_req = 1'b0;
  endtask

  function automatic exp_t model_read(input int s);
    exp_t e;
    e = '0;
    if (m_val[s]) begin
      e.p = m_fld[s][0]; e.n = m_fld[s][1]; e.a  = m_fld[s][2];
      e.b = m_fld[s][3]; e.gx = m_fld[s][4]; e.gy = m_fld[s][5];
    end
    return e;
  endfunction

  // Advance the model by one clock edge given the inputs presented this cycle.
  task automatic model_edge();
    logic [255:0] fld;
    case (ph)
      0: if (load_start) begin ph = 1; m_tgt = int'(load_slot); m_cnt = 0; end
      1: begin
        if (load_abort) ph = 0;
        else if (wr_valid) begin
          m_words[m_cnt] = wr_data;
          m_cnt++;
          if (m_cnt == 48) ph = 2;
        end
      end
      2: begin
        for (int f = 0; f < 6; f++) begin
          fld = 256'h0;
          for (int w = 0; w < 8; w++) fld = {fld[223:0], m_words[f*8 + w]};
          m_fld[m_tgt][f] = fld;
        end
        m_val[m_tgt] = 1'b1;
        ph = 0;
      end
      default: ph = 0;
    endcase
  endtask

  // One cycle: called at a negedge with load inputs already driven.
  task automatic tick();
    if (rd_fix >= 0) begin
      rd_req  = 1'b1;
      rd_slot = 2'(rd_fix);
    end else begin
      rd_req  = 1'($urandom_range(0, 1));
      rd_slot = 2'($urandom_range(0, 3));
    end
    if (rd_req) q.push_back(model_read(int'(rd_slot)));
    check("wr_ready", wr_ready, (ph == 1));
    check("busy", busy, (ph != 0));
    check("load_done", load_done, (ph == 2));
    check("slot_valid", slot_valid, m_val);
    check("rd_valid", rd_valid, last_req);
    last_req = rd_req;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_word(input int mode, input int k);
    case (mode)
      0:       return 32'(k);
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // gap: 0 continuous, 1 alternate cycles, 2 random. abort_at < 0 means no abort.
  task automatic do_load(input int slot, input int mode, input int gap, input int abort_at);
    int  guard;
    bit  tog;
    load_start = 1'b1;
    load_slot  = 2'(slot);
    wr_valid   = 1'b0;
    tick();
    guard = 0;
    tog   = 1'b1;
    while (ph == 1 && guard < 400) begin
      case (gap)
        0:       wr_valid = 1'b1;
        1:       begin wr_valid = tog; tog = ~tog; end
        default: wr_valid = 1'($urandom_range(0, 1));
      endcase
      wr_data    = gen_word(mode, m_cnt);
      load_abort = (abort_at >= 0 && m_cnt == abort_at);
      if (load_abort) wr_valid = 1'b1;
      load_start = ($urandom_range(0, 3) == 0);
      load_slot  = 2'($urandom_range(0, 3));
      tick();
      guard++;
    end
    load_abort = 1'b0;
    load_start = 1'b0;
    if (ph == 2) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // Scoreboard monitor: pops one expectation for every valid read response.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected rd_valid=1 with no request outstanding");
        end else begin
          e = q.pop_front();
          g = {rd_p, rd_n, rd_a, rd_b, rd_gx, rd_gy};
          if (g !== e) begin
            n_bad++;
            for (int f = 0; f < 6; f++)
              if (g[(5-f)*256 +: 256] !== e[(5-f)*256 +: 256])
                $display("FAIL rd_field%0d got=%h exp=%h", f, g[(5-f)*256 +: 256], e[(5-f)*256 +: 256]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    load_start = 1'b0; load_slot = 2'd0; load_abort = 1'b0;
    wr_valid = 1'b0; wr_data = 32'd0; rd_req = 1'b0; rd_slot = 2'd0;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_p_zero", (rd_p == 256'h0), 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_slot_valid", slot_valid, 4'b0001);
    reset_n = 1'b1;

    rd_fix = 0; tick(); tick();
    rd_fix = -1; repeat (3) tick();

    do_load(2, 0, 0, -1);           // word i = i
    repeat (2) tick();
    do_load(2, 0, 1, -1);           // same data, wr_valid alternating
    rd_fix = 2; tick(); rd_fix = -1;

    do_load(1, 2, 0, 20);           // abort after 20 words
    rd_fix = 1; tick(); rd_fix = -1;
    do_load(1, 2, 2, -1);
    rd_fix = 1; tick();

    rd_fix = 2;                     // reload slot 2 while reading it every cycle
    do_load(2, 1, 0, -1);
    repeat (2) tick();
    rd_fix = -1;

    for (int i = 0; i < 5; i++)
      do_load($urandom_range(0, 3), 2, 2, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 47) : -1);
    repeat (3) tick();

    // Reset in the middle of loading slot 3.
    load_start = 1'b1; load_slot = 2'd3;
    tick();
    load_start = 1'b0;
    rd_fix = 0;
    repeat (10) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      tick();
    end
    rd_fix   = -1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midrst_rd_valid", rd_valid, 1'b0);
    check("midrst_wr_ready", wr_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd_p_zero", (rd_p == 256'h0), 1'b1);
    check("midrst_rd_gx_zero", (rd_gx == 256'h0), 1'b1);
    check("midrst_slot_valid", slot_valid, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();

    for (int s = 0; s < 4; s++) begin
      rd_fix = s;
      tick();
    end
    rd_fix = -1;
    do_load(3, 2, 0, -1);
    rd_fix = 3; tick(); rd_fix = -1;
    repeat (4) tick();

    check("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
